// File: rtl/spi_write_decoder_if.sv
// Byte stream from spi_slave plus the write-request port toward memory_arbiter.
// The decoder takes the slave modport; the bench or upstream glue takes master.
interface spi_write_decoder_if #(
    parameter int ADDRESS_WIDTH = 25
);
    logic [7:0]               data_in;
    logic                     data_in_ready;
    logic                     cs_n;
    logic [ADDRESS_WIDTH-1:0] address_mem;
    logic                     wr_mem;
    logic [7:0]               data_out_mem;
    logic                     data_out_ready_mem;
    logic                     fifo_full_mem;
    logic                     busy;
    logic                     overflow;

    modport slave (
        input  data_in, data_in_ready, cs_n, fifo_full_mem,
        output address_mem, wr_mem, data_out_mem, data_out_ready_mem, busy, overflow
    );

    modport master (
        output data_in, data_in_ready, cs_n, fifo_full_mem,
        input  address_mem, wr_mem, data_out_mem, data_out_ready_mem, busy, overflow
    );
endinterface

// File: rtl/spi_write_decoder.sv
// Generic synchronous FIFO; show-ahead read, 1-cycle write-to-visible.
// Caller must not push when full unless it pops in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_i && !pop_i)      count_d = count_q + (PW+1)'(1);
        else if (!push_i && pop_i) count_d = count_q - (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == (PW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
endmodule

// Decodes cs_n-framed SPI bytes (cmd, 32-bit BE address, payload) into arbiter writes.
// Byte at cycle N reaches the arbiter at N+2; a FIFO absorbs fifo_full_mem stalls, excess bytes set overflow.
module spi_write_decoder #(
    parameter int             ADDRESS_WIDTH = 25,
    parameter int             FIFO_DEPTH    = 16,
    parameter logic [7:0]     CMD_WRITE     = 8'h01
) (
    input  logic              clk,
    input  logic              reset,
    spi_write_decoder_if.slave bus
);
    localparam int AW = ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_DISCARD
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    addr_idx_q, addr_idx_d;
    logic [AW-1:0] addr_acc_q, addr_acc_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic          overflow_q, overflow_d;
    logic          cs_s1_q, cs_s2_q, cs_prev_q;
    logic [2:0]    primed_q;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [7:0]    req_dat_q, req_dat_d;
    logic          req_vld_q, req_vld_d;

    logic          frame_start;
    logic          want_push, push, pop;
    logic          fifo_full, fifo_empty;
    logic [AW+7:0] fifo_head;

    // primed_q marks when cs_prev_q holds a real sample rather than its reset
    // value, so cs_n held low across reset cannot fake a falling edge.
    assign frame_start = primed_q[2] & cs_prev_q & ~cs_s2_q;
    assign pop         = ~fifo_empty & ~bus.fifo_full_mem;
    assign push        = want_push & (~fifo_full | pop);

    always_comb begin
        state_d    = state_q;
        addr_idx_d = addr_idx_q;
        addr_acc_d = addr_acc_q;
        cur_addr_d = cur_addr_q;
        overflow_d = overflow_q;
        want_push  = 1'b0;
        if (frame_start) begin
            state_d    = S_CMD;
            addr_idx_d = 2'd0;
        end else if (bus.data_in_ready) begin
            case (state_q)
                S_CMD: begin
                    addr_idx_d = 2'd0;
                    state_d    = (bus.data_in == CMD_WRITE) ? S_ADDR : S_DISCARD;
                end
                S_ADDR: begin
                    addr_acc_d = (addr_acc_q << 8) | AW'(bus.data_in);
                    addr_idx_d = addr_idx_q + 2'd1;
                    if (addr_idx_q == 2'd3) begin
                        cur_addr_d = addr_acc_d;
                        state_d    = S_DATA;
                    end
                end
                S_DATA: begin
                    want_push  = 1'b1;
                    cur_addr_d = cur_addr_q + AW'(1);
                    if (fifo_full && !pop) overflow_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_vld_d  = pop;
        req_addr_d = req_addr_q;
        req_dat_d  = req_dat_q;
        if (pop) begin
            req_addr_d = fifo_head[AW+7:8];
            req_dat_d  = fifo_head[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_idx_q <= 2'd0;
            addr_acc_q <= '0;
            cur_addr_q <= '0;
            overflow_q <= 1'b0;
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            cs_prev_q  <= 1'b1;
            primed_q   <= 3'b000;
            req_addr_q <= '0;
            req_dat_q  <= 8'h00;
            req_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_idx_q <= addr_idx_d;
            addr_acc_q <= addr_acc_d;
            cur_addr_q <= cur_addr_d;
            overflow_q <= overflow_d;
            cs_s1_q    <= bus.cs_n;
            cs_s2_q    <= cs_s1_q;
            cs_prev_q  <= cs_s2_q;
            primed_q   <= {primed_q[1:0], 1'b1};
            req_addr_q <= req_addr_d;
            req_dat_q  <= req_dat_d;
            req_vld_q  <= req_vld_d;
        end
    end

    sync_fifo #(
        .WIDTH (AW + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i ({cur_addr_q, bus.data_in}),
        .pop_i      (pop),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign bus.address_mem        = req_addr_q;
    assign bus.data_out_mem       = req_dat_q;
    assign bus.data_out_ready_mem = req_vld_q;
    assign bus.wr_mem             = 1'b1;
    assign bus.busy               = ~fifo_empty | req_vld_q;
    assign bus.overflow           = overflow_q;
endmodule

// File: tb/tb_spi_write_decoder.sv
// Bench for spi_write_decoder: directed frames plus random frames against a
// byte-position reference model of the frame format.
module tb_spi_write_decoder;
    localparam int AW    = 25;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_write_decoder_if #(.ADDRESS_WIDTH(AW)) bus_if ();

    spi_write_decoder #(
        .ADDRESS_WIDTH (AW),
        .FIFO_DEPTH    (DEPTH),
        .CMD_WRITE     (8'h01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  n_strobes = 0;
    int  n_pushed  = 0;
    int  last_pulse_cyc = 0;
    int  strobe_cyc[$];
    wr_t exp_q[$];

    bit            in_frame = 1'b0;
    bit            is_write = 1'b0;
    int            pos = 0;
    logic [31:0]   abuf = '0;
    logic [AW-1:0] base = '0;
    bit            exp_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!reset && bus_if.data_out_ready_mem === 1'b1) begin
            n_strobes++;
            strobe_cyc.push_back(cyc);
            check("strobe_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(bus_if.address_mem), 64'(e.a));
                check("wr_data", 64'(bus_if.data_out_mem), 64'(e.d));
                check("wr_mem", 64'(bus_if.wr_mem), 64'd1);
            end
        end
    end

    // Frame model: position 0 is the command, 1..4 the address, 5+ payload.
    task automatic model_byte(input logic [7:0] b);
        wr_t w;
        if (!in_frame) return;
        if (pos == 0) begin
            is_write = (b == 8'h01);
        end else if (is_write) begin
            if (pos <= 4) abuf = {abuf[23:0], b};
            if (pos == 4) base = abuf[AW-1:0];
            if (pos >= 5) begin
                w.a = base + AW'(pos - 5);
                w.d = b;
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(w);
                    n_pushed++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        pos++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        bus_if.cs_n = 1'b1;
        tick(4);
        bus_if.cs_n = 1'b0;
        tick(5);
        in_frame = 1'b1;
        pos      = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.data_in       = b;
        bus_if.data_in_ready = 1'b1;
        last_pulse_cyc       = cyc;
        model_byte(b);
        tick(1);
        bus_if.data_in_ready = 1'b0;
        tick(2);
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
    endtask

    task automatic do_reset_model();
        exp_q.delete();
        in_frame = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || bus_if.busy !== 1'b0) && k < 300) begin
            tick(1);
            k++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
        check({tag, "_overflow"}, 64'(bus_if.overflow), 64'(exp_ovf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] cmd;
        int         n, s0, p0, aa_cyc;
        bit         stall, late;

        bus_if.data_in       = 8'h00;
        bus_if.data_in_ready = 1'b0;
        bus_if.cs_n          = 1'b1;
        bus_if.fifo_full_mem = 1'b0;

        // Reset state
        reset = 1'b1;
        tick(3);
        check("rst_address", 64'(bus_if.address_mem), 64'd0);
        check("rst_data", 64'(bus_if.data_out_mem), 64'd0);
        check("rst_strobe", 64'(bus_if.data_out_ready_mem), 64'd0);
        check("rst_wr_mem", 64'(bus_if.wr_mem), 64'd1);
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_overflow", 64'(bus_if.overflow), 64'd0);
        reset = 1'b0;
        tick(2);

        // Basic write and first-strobe latency
        frame_start();
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h01, 8'h00});
        s0 = n_strobes;
        strobe_cyc.delete();
        send_byte(8'hAA);
        aa_cyc = last_pulse_cyc;
        send_bytes('{8'hBB, 8'hCC});
        bus_if.cs_n = 1'b1;
        wait_drain("basic");
        check("basic_count", 64'(n_strobes - s0), 64'd3);
        if (strobe_cyc.size() != 0)
            check("basic_latency", 64'(strobe_cyc[0] - aa_cyc), 64'd2);

        // Backpressure: 20 stalled cycles from the AA byte
        frame_start();
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h01, 8'h00});
        s0 = n_strobes;
        strobe_cyc.delete();
        bus_if.fifo_full_mem = 1'b1;
        send_bytes('{8'hAA, 8'hBB, 8'hCC});
        tick(11);
        check("bp_no_strobe", 64'(n_strobes - s0), 64'd0);
        check("bp_busy_stalled", 64'(bus_if.busy), 64'd1);
        bus_if.fifo_full_mem = 1'b0;
        wait_drain("bp");
        check("bp_count", 64'(strobe_cyc.size()), 64'd3);
        if (strobe_cyc.size() == 3) begin
            check("bp_consec01", 64'(strobe_cyc[1] - strobe_cyc[0]), 64'd1);
            check("bp_consec12", 64'(strobe_cyc[2] - strobe_cyc[1]), 64'd1);
        end

        // Overflow with a depth-4 FIFO
        bus_if.fifo_full_mem = 1'b1;
        frame_start();
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h10});
        s0 = n_strobes;
        send_bytes('{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        check("ovf_flag", 64'(bus_if.overflow), 64'(exp_ovf));
        check("ovf_model_flag", 64'(exp_ovf), 64'd1);
        bus_if.fifo_full_mem = 1'b0;
        wait_drain("ovf");
        check("ovf_count", 64'(n_strobes - s0), 64'd4);

        // Ignored command, then a write-looking sequence inside the same frame
        frame_start();
        s0 = n_strobes;
        send_bytes('{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22});
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33});
        wait_drain("ignore");
        check("ignore_count", 64'(n_strobes - s0), 64'd0);

        // Address wrap at 2^25
        frame_start();
        s0 = n_strobes;
        send_bytes('{8'h01, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'hA5});
        wait_drain("wrap");
        check("wrap_count", 64'(n_strobes - s0), 64'd2);

        // Random frames, some stalled, some with a byte after cs_n rises
        for (int f = 0; f < 12; f++) begin
            cmd   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01;
            n     = $urandom_range(0, 6);
            stall = 1'($urandom_range(0, 1));
            late  = 1'($urandom_range(0, 1));
            frame_start();
            send_byte(cmd);
            for (int i = 0; i < 4; i++) send_byte(8'($urandom));
            s0 = n_strobes;
            p0 = n_pushed;
            bus_if.fifo_full_mem = stall;
            for (int i = 0; i < n; i++) begin
                if (late && i == n - 1) bus_if.cs_n = 1'b1;
                send_byte(8'($urandom));
            end
            bus_if.fifo_full_mem = 1'b0;
            wait_drain("rand");
            check("rand_count", 64'(n_strobes - s0), 64'(n_pushed - p0));
        end

        // Reset mid-frame with entries queued; cs_n stays low afterwards
        bus_if.fifo_full_mem = 1'b1;
        frame_start();
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'h40, 8'h41});
        check("rstmid_busy_before", 64'(bus_if.busy), 64'd1);
        reset = 1'b1;
        tick(2);
        bus_if.fifo_full_mem = 1'b0;
        reset = 1'b0;
        do_reset_model();
        tick(1);
        s0 = n_strobes;
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'h50, 8'h51});
        tick(5);
        check("rstmid_count", 64'(n_strobes - s0), 64'd0);
        check("rstmid_busy", 64'(bus_if.busy), 64'd0);
        check("rstmid_overflow", 64'(bus_if.overflow), 64'd0);

        // A genuine new frame after reset decodes normally
        frame_start();
        s0 = n_strobes;
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h30, 8'h77});
        wait_drain("post");
        check("post_count", 64'(n_strobes - s0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_write_decoder.md
Name: spi_write_decoder

Overview:
Decodes the byte stream from spi_slave into addressed memory writes for one memory_arbiter peripheral port. Each chip-select frame is command, 32-bit address, then payload. Payload bytes are written to consecutive addresses. An internal FIFO absorbs arbiter backpressure, because the SPI side cannot stall.

Parameters:
ADDRESS_WIDTH, 25, width of the memory address; the decoded 32-bit address is truncated to its LSBs.
FIFO_DEPTH, 16, number of pending {address,data} entries; must be a power of 2 and at least 2.
CMD_WRITE, 8'h01, command byte that selects an incrementing write.

Ports:
clk  in  1  system clock (clk_sys domain)
reset  in  1  synchronous, active-high reset
data_in  in  8  received SPI byte, valid with data_in_ready
data_in_ready  in  1  one-cycle byte-valid pulse from spi_slave
cs_n  in  1  raw SPI chip select, asynchronous, active low
address_mem  out  ADDRESS_WIDTH  write address to the arbiter
wr_mem  out  1  write/read select to the arbiter; this block always drives 1
data_out_mem  out  8  write data to the arbiter
data_out_ready_mem  out  1  one-cycle request strobe to the arbiter
fifo_full_mem  in  1  arbiter port full; no request may be issued while it is high
busy  out  1  high when the FIFO is non-empty or a request strobe is outstanding
overflow  out  1  sticky flag: a payload byte was dropped because the FIFO was full

Behaviour:
- cs_n passes through a 2-flop synchroniser. A frame starts on a synchronised falling edge (previous 1, current 0).
- Frame start forces the state to CMD and clears the byte counter, from any state.
- A frame does not end on cs_n rising. Bytes that arrive late after the rise still belong to the current frame.
- States:
  - IDLE: reset state. All bytes are dropped.
  - CMD: next byte equal to CMD_WRITE -> ADDR with addr_idx=0. Any other value -> DISCARD.
  - ADDR: four bytes, big-endian, shifted into a 32-bit register. After the 4th byte, the current address = reg[ADDRESS_WIDTH-1:0] -> DATA.
  - DATA: each byte pushes {current address, data_in} into the FIFO, then the current address increments modulo 2^ADDRESS_WIDTH (0x1FFFFFF+1 -> 0).
  - DISCARD: all bytes dropped until the next frame start.
- FIFO full in DATA:
  - The byte is dropped and overflow is set.
  - The address still increments, so later bytes land at their intended addresses.
  - overflow clears only on reset.
- A push and a pop in the same cycle on a full FIFO are both legal; the FIFO count is unchanged.
- Push timing: the push occurs in the cycle after data_in_ready is sampled, so the FIFO is written at cycle N+1.
- Issue logic (registered outputs):
  - Each cycle where the FIFO is non-empty and fifo_full_mem=0: pop one entry, and on the next edge drive address_mem/data_out_mem with it and pulse data_out_ready_mem for one cycle.
  - Back-to-back requests are allowed, one per cycle.
  - fifo_full_mem is sampled in the pop cycle. If it is high, no pop occurs and data_out_ready_mem is 0 next cycle.
- Latency: data_in_ready at cycle N into an empty FIFO with fifo_full_mem=0 gives data_out_ready_mem high at cycle N+2.
- Writes are issued in arrival order. No reordering or merging.
- Reset values:
  - state=IDLE, FIFO empty, synchroniser flops=1.
  - address_mem=0, data_out_mem=0, data_out_ready_mem=0, wr_mem=1, busy=0, overflow=0.
- Reset mid-frame discards the FIFO contents and the partial address. After reset, the block waits for a new cs_n falling edge.
- A new frame starting while the FIFO still holds entries from the previous frame does not flush the FIFO; the old entries drain normally.

Test Plan:
- Basic write:
  - Stimulus: cs_n falls, then bytes 01 00 00 01 00 AA BB CC, fifo_full_mem=0.
  - Response: three strobes, (0x000100,AA), (0x000101,BB), (0x000102,CC). First strobe 2 cycles after the AA pulse.
- Backpressure:
  - Stimulus: same frame, with fifo_full_mem held high for 20 cycles from the AA byte.
  - Response: no strobes while it is high. After release, 3 strobes on consecutive cycles, in order. busy drops after the last strobe.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, fifo_full_mem=1, frame 01 00 00 00 10 followed by 6 bytes 00..05, then release.
  - Response: overflow=1. Exactly 4 writes, (0x10,00)..(0x13,03).
- Ignored command:
  - Stimulus: frame 7F 00 00 00 00 11 22.
  - Response: zero strobes. State stays DISCARD until the next cs_n fall.
- Wrap:
  - Stimulus: frame 01 01 FF FF FF 5A A5.
  - Response: writes (0x1FFFFFF,5A) then (0x0000000,A5).
- Reset mid-frame:
  - Stimulus: reset asserted after 2 payload bytes are queued with fifo_full_mem=1, then released with fifo_full_mem=0 and further bytes sent without a new cs_n fall.
  - Response: no strobes, busy=0, overflow=0.
